// File: rtl/em_pkg.sv
// em_pkg: shared widths, opcodes and FSM states for the stack-machine execution controller
package em_pkg;
   localparam int DEF_OPCODE_W    = 16;
   localparam int DEF_PC_W        = 10;
   localparam int DEF_WORD_W      = 256;
   localparam int DEF_STACK_DEPTH = 128;
   localparam int PC_MAX          = 1022;
   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_PUSHI = 4'd1,
      OP_POP   = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_DUP   = 4'd5,
      OP_JUMP  = 4'd6,
      OP_JUMPI = 4'd7,
      OP_HALT  = 4'd8
   } opcode_e;
   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_SETTLE,
      S_HALT,
      S_FAULT
   } state_e;
endpackage

// File: rtl/exec_decode.sv
// exec_decode: combinational opcode decode with stack-depth, jump-target and pc-range legality
module exec_decode
   import em_pkg::*;
#(
   parameter int PC_W        = DEF_PC_W,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH,
   parameter int DEPTH_W     = $clog2(DEF_STACK_DEPTH + 1)
) (
   input  logic [3:0]         op,
   input  logic [DEPTH_W-1:0] depth,
   input  logic [WORD_W-1:0]  top,
   input  logic [WORD_W-1:0]  next,
   input  logic [PC_W-1:0]    pc,
   output logic [2:0]         pop_n,
   output logic               push,
   output logic               jump,
   output logic               halt,
   output logic               fault
);
   opcode_e    op_e;
   logic [1:0] need;
   logic       illegal;
   logic       underflow;
   logic       overflow;
   logic       bad_target;
   logic       bad_inc;
   always_comb begin
      op_e       = opcode_e'(op);
      pop_n      = (op_e == OP_POP || op_e == OP_JUMP) ? 3'd1 :
                   (op_e == OP_ADD || op_e == OP_SUB || op_e == OP_JUMPI) ? 3'd2 : 3'd0;
      need       = (op_e == OP_DUP) ? 2'd1 : pop_n[1:0];
      push       = op_e inside {OP_PUSHI, OP_ADD, OP_SUB, OP_DUP};
      halt       = op_e == OP_HALT;
      jump       = op_e == OP_JUMP || (op_e == OP_JUMPI && next != '0);
      illegal    = op > 4'(OP_HALT);
      underflow  = depth < DEPTH_W'(need);
      overflow   = (op_e == OP_PUSHI || op_e == OP_DUP) && depth == DEPTH_W'(STACK_DEPTH);
      bad_target = (|top[WORD_W-1:PC_W]) || top[PC_W-1:0] > PC_W'(PC_MAX);
      // a not-taken JUMPI still increments, so it is subject to the pc ceiling
      bad_inc    = !jump && !halt && pc == PC_W'(PC_MAX);
      fault      = illegal || underflow || overflow || (jump && bad_target) || bad_inc;
   end
endmodule

// File: rtl/exec_control.sv
// exec_control: three-cycle FETCH/EXEC/SETTLE sequencer driving an external pc and operand stack
module exec_control
   import em_pkg::*;
#(
   parameter int OPCODE_W    = DEF_OPCODE_W,
   parameter int PC_W        = DEF_PC_W,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] rom_data,
   input  logic [PC_W-1:0]     pc,
   output logic                pc_load,
   output logic                pc_inc,
   output logic [PC_W-1:0]     pc_load_val,
   output logic                stack_push,
   output logic [WORD_W-1:0]   stack_push_data,
   output logic [2:0]          stack_pop,
   input  logic [WORD_W-1:0]   stack_top,
   input  logic [WORD_W-1:0]   stack_next,
   output logic                halted,
   output logic                fault
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   state_e             state_q, state_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [3:0]         op;
   logic [OPCODE_W-5:0] imm;
   logic [2:0]         pop_n;
   logic               push;
   logic               jump;
   logic               halt_op;
   logic               bad;
   logic               commit;
   assign op  = rom_data[OPCODE_W-1 -: 4];
   assign imm = rom_data[OPCODE_W-5:0];
   exec_decode #(
      .PC_W        (PC_W),
      .WORD_W      (WORD_W),
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     (DEPTH_W)
   ) u_decode (
      .op    (op),
      .depth (depth_q),
      .top   (stack_top),
      .next  (stack_next),
      .pc    (pc),
      .pop_n (pop_n),
      .push  (push),
      .jump  (jump),
      .halt  (halt_op),
      .fault (bad)
   );
   // strobes are pure functions of the registered state, so an async reset kills them at once
   always_comb begin
      commit  = state_q == S_EXEC && !bad && !halt_op;
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_EXEC;
         S_EXEC:   state_d = bad ? S_FAULT : halt_op ? S_HALT : S_SETTLE;
         S_SETTLE: state_d = S_FETCH;
         default:  state_d = state_q;
      endcase
      depth_d         = commit ? depth_q + DEPTH_W'(push) - DEPTH_W'(pop_n) : depth_q;
      stack_push      = commit && push;
      stack_pop       = commit ? pop_n : 3'd0;
      pc_load         = commit && jump;
      pc_inc          = commit && !jump;
      pc_load_val     = pc_load ? stack_top[PC_W-1:0] : '0;
      stack_push_data = !stack_push ? '0 :
                        op == 4'(OP_PUSHI) ? WORD_W'(imm) :
                        op == 4'(OP_ADD) ? stack_next + stack_top :
                        op == 4'(OP_SUB) ? stack_next - stack_top : stack_top;
      halted          = state_q == S_HALT;
      fault           = state_q == S_FAULT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         depth_q <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
      end
   end
endmodule

// File: doc/exec_control.md
EXEC_CONTROL -- requirements
Module: exec_control

Interface
REQ-001 SHALL take parameters: OPCODE_W = 16 (instruction bits); PC_W = 10 (program-counter bits); WORD_W = 256 (stack word bits); STACK_DEPTH = 128 (stack entries).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port rom_data, input, OPCODE_W bits: instruction read from ROM at pc, valid one cycle after pc is presented.
REQ-005 SHALL have port pc, input, PC_W bits: current program-counter value.
REQ-006 SHALL have port pc_load, output, 1 bit: one-cycle pulse that loads pc_load_val into the program counter.
REQ-007 SHALL have port pc_inc, output, 1 bit: one-cycle pulse that increments the program counter.
REQ-008 SHALL have port pc_load_val, output, PC_W bits: jump target.
REQ-009 SHALL have port stack_push, output, 1 bit: one-cycle push pulse.
REQ-010 SHALL have port stack_push_data, output, WORD_W bits: word to push.
REQ-011 SHALL have port stack_pop, output, 3 bits: number of words to pop this cycle; pops are applied before the push in the same cycle.
REQ-012 SHALL have port stack_top, input, WORD_W bits: stack preview[0].
REQ-013 SHALL have port stack_next, input, WORD_W bits: stack preview[1].
REQ-014 SHALL have ports halted and fault, output, 1 bit each: sticky status flags.

Function
REQ-015 SHALL decode each instruction as op = rom_data[15:12] and imm = rom_data[11:0].
REQ-016 SHALL implement these opcodes:
- 0 NOP
- 1 PUSHI: push imm zero-extended to WORD_W
- 2 POP
- 3 ADD: pop 2, push (next + top) mod 2^256
- 4 SUB: pop 2, push (next - top) mod 2^256
- 5 DUP: push top
- 6 JUMP: pop 1, pc <- top
- 7 JUMPI: pop 2, jump to top if next != 0
- 8 HALT
- 9..15: illegal
REQ-017 SHALL use FSM states FETCH, EXEC, SETTLE, HALT, FAULT; every instruction takes exactly 3 cycles (FETCH -> EXEC -> SETTLE -> FETCH).
REQ-018 SHALL assert all pc/stack strobes only in EXEC, for exactly one cycle; in EXEC, exactly one of pc_inc or pc_load is asserted unless the instruction faults or halts.
REQ-019 SHALL track stack depth internally (0..STACK_DEPTH), updating it in EXEC by push - pop.
REQ-020 SHALL treat underflow (depth below operand count: POP/DUP/JUMP need 1, ADD/SUB/JUMPI need 2) as a fault.
REQ-021 SHALL treat overflow (PUSHI/DUP at depth == STACK_DEPTH) as a fault; ADD/SUB at full depth is legal.
REQ-022 SHALL treat these as faults: a JUMP/JUMPI taken with top[255:10] != 0 or top[9:0] > 1022; and pc_inc at pc == 1022.
REQ-023 SHALL treat JUMPI not taken as a pop of 2 plus pc_inc; the target is not range-checked in this case.
REQ-024 SHALL, on any fault, issue no strobes and leave depth unchanged; enter FAULT with fault=1, held until reset.
REQ-025 SHALL, on HALT, issue no strobes; enter HALT with halted=1, held until reset; pc stays at the HALT address.
REQ-026 SHALL drive stack_push_data and pc_load_val to 0 whenever their strobes are low.

Reset
REQ-027 SHALL, while rst=1, immediately force: state FETCH; depth 0; all outputs 0.
REQ-028 SHALL, when reset is asserted mid-EXEC, drop strobes in the same cycle, with no partial commit tracked.
REQ-029 SHALL begin FETCH on the first clk edge after rst deasserts.

Structure
REQ-030 SHALL take opcode enum, widths, STACK_DEPTH and max-PC constant from shared package em_pkg.
REQ-031 SHALL place combinational decode (operand count, push/pop amounts, legality) in sub-module exec_decode; FSM, depth counter and adder/subtractor stay in exec_control.

Verification
REQ-032 SHALL cover: PUSHI 5; PUSHI 7; ADD; HALT -> push data 0x7 then 0xC, pop=2 with push on ADD, depth 1, halted=1 at cycle 12.
REQ-033 SHALL cover: PUSHI 3; PUSHI 5; SUB -> pushed value 2^256-2, no fault.
REQ-034 SHALL cover: POP with empty stack -> fault=1, no strobes, pc unchanged.
REQ-035 SHALL cover: 128 PUSHI then PUSHI -> 129th faults, depth stays 128, stack_push never high.
REQ-036 SHALL cover: PUSHI 1; PUSHI 40; JUMPI -> pc_load=1, pc_load_val=40; and PUSHI 0; PUSHI 40; JUMPI -> pc_inc=1 only.
REQ-037 SHALL cover: PUSHI 1023; JUMP -> fault; and rst pulsed during EXEC -> strobes low same cycle, depth 0.
